alu_mult_sequencer: RTL and testbench

Multi-cycle signed 32×32 multiplier that borrows the processor's shared 32-bit ALU for its add and subtract steps instead of instantiating its own adder. It sequences radix-2 Booth iterations, driving the ALU operand and opcode inputs one step per cycle, and holds the partial-product state between steps. It sits beside the execute stage, which owns the ALU whenever this block is idle. Results come back through a start/ready handshake with an overflow exception flag.

---
 rtl/alu_mult_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_mult_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_sequencer.sv
// Radix-2 Booth sequencer for signed 32x32 multiply. It borrows the shared ALU
// for its add/subtract steps and reports the low product word and an overflow flag.
module alu_mult_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shiftamt,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  output logic        busy,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] q_q, q_d;
  logic        q1_q, q1_d;
  logic [31:0] m_q, m_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [31:0] step_sum;
  logic        step_sgn;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    q_d            = q_q;
    q1_d           = q1_q;
    m_d            = m_q;
    cnt_d          = cnt_q;
    alu_operandA   = '0;
    alu_operandB   = '0;
    alu_opcode     = 5'd0;
    alu_shiftamt   = 5'd0;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    step_sum       = a_q;
    step_sgn       = a_q[31];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = data_operandA;
          q_d     = data_operandB;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end

      S_ITER: begin
        busy         = 1'b1;
        alu_operandA = a_q;
        alu_operandB = m_q;
        // The XOR with overflow recovers the true 33-bit sign of A +/- M,
        // which the 32-bit result alone gets wrong when M = 0x80000000.
        case ({q_q[0], q1_q})
          2'b01: begin
            alu_opcode = 5'd0;
            step_sum   = alu_result;
            step_sgn   = alu_result[31] ^ alu_overflow;
          end
          2'b10: begin
            alu_opcode = 5'd1;
            step_sum   = alu_result;
            step_sgn   = alu_result[31] ^ alu_overflow;
          end
          default: begin
            alu_opcode = 5'd0;
          end
        endcase
        a_d   = {step_sgn, step_sum[31:1]};
        q_d   = {step_sum[0], q_q[31:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        busy           = 1'b1;
        data_resultRDY = 1'b1;
        state_d        = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign data_result    = q_q;
  assign data_exception = (a_q != {32{q_q[31]}});

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Bench for alu_mult_sequencer: models the shared ALU and checks products,
// timing and handshake against 64-bit signed multiplication.
module tb_alu_mult_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [4:0]  alu_opcode;
  logic [4:0]  alu_shiftamt;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        busy;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mult_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .alu_operandA   (alu_operandA),
    .alu_operandB   (alu_operandB),
    .alu_opcode     (alu_opcode),
    .alu_shiftamt   (alu_shiftamt),
    .alu_result     (alu_result),
    .alu_overflow   (alu_overflow),
    .busy           (busy),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared ALU: opcode 1 subtracts, anything else adds; signed overflow flag.
  always_comb begin
    if (alu_opcode == 5'd1) begin
      alu_result   = alu_operandA - alu_operandB;
      alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
    end else begin
      alu_result   = alu_operandA + alu_operandB;
      alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
    end
  end

  function automatic logic [32:0] ref_product(input logic [31:0] m, input logic [31:0] q);
    logic signed [63:0] ms, qs, prod;
    ms   = $signed(m);
    qs   = $signed(q);
    prod = ms * qs;
    return {(prod != {{32{prod[31]}}, prod[31:0]}), prod[31:0]};
  endfunction

  // Called just after a falling edge; starts in that cycle (cycle 0) and
  // returns after sampling cycle 34, so calls chain back to back.
  task automatic run_op(input logic [31:0] m, input logic [31:0] q, input string tag);
    logic [32:0] exp;
    exp           = ref_product(m, q);
    start         = 1'b1;
    data_operandA = m;
    data_operandB = q;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clock);
      if (c == 1) begin
        start         = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
      end
      n_checks++;
      if (busy !== (c <= 33)) begin
        n_fail++;
        $display("FAIL %s busy cycle %0d: got %b expected %b", tag, c, busy, (c <= 33));
      end
      n_checks++;
      if (data_resultRDY !== (c == 33)) begin
        n_fail++;
        $display("FAIL %s rdy cycle %0d: got %b expected %b", tag, c, data_resultRDY, (c == 33));
      end
      if (c <= 32) begin
        n_checks++;
        if (alu_operandB !== m || alu_shiftamt !== 5'd0) begin
          n_fail++;
          $display("FAIL %s alu_drive cycle %0d: got opB=%h shamt=%0d expected opB=%h shamt=0",
                   tag, c, alu_operandB, alu_shiftamt, m);
        end
      end
      if (c == 33 || c == 34) begin
        n_checks++;
        if (data_result !== exp[31:0] || data_exception !== exp[32]) begin
          n_fail++;
          $display("FAIL %s result cycle %0d: got %h exc=%b expected %h exc=%b",
                   tag, c, data_result, data_exception, exp[31:0], exp[32]);
        end
      end
      if (c == 34) begin
        n_checks++;
        if (alu_operandA !== 32'd0 || alu_operandB !== 32'd0 || alu_opcode !== 5'd0) begin
          n_fail++;
          $display("FAIL %s alu_idle: got opA=%h opB=%h op=%0d expected zeros",
                   tag, alu_operandA, alu_operandB, alu_opcode);
        end
      end
    end
    $display("op %s: M=%h Q=%h -> result=%h exc=%b (expected %h exc=%b)",
             tag, m, q, data_result, data_exception, exp[31:0], exp[32]);
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if (busy !== 1'b0 || data_resultRDY !== 1'b0 || data_result !== 32'd0 ||
        data_exception !== 1'b0 || alu_operandA !== 32'd0 || alu_operandB !== 32'd0 ||
        alu_opcode !== 5'd0 || alu_shiftamt !== 5'd0) begin
      n_fail++;
      $display("FAIL %s outputs: got busy=%b rdy=%b res=%h exc=%b opA=%h opB=%h op=%0d expected all zero",
               tag, busy, data_resultRDY, data_result, data_exception, alu_operandA, alu_operandB, alu_opcode);
    end
  endtask

  task automatic test_reset;
    reset_n       = 1'b0;
    start         = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #3;
    check_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_all_zero("post_reset_idle");
    $display("reset: outputs checked zero");
  endtask

  task automatic test_directed;
    run_op(32'd3, 32'd5, "3x5");
    run_op(32'hFFFF_FFF9, 32'd6, "-7x6");
    run_op(32'h8000_0000, 32'd1, "min_x1");
    run_op(32'h7FFF_FFFF, 32'd2, "max_x2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, "min_xneg1");
  endtask

  task automatic test_start_held;
    int rdy_count;
    logic exp_busy, exp_rdy;
    rdy_count     = 0;
    start         = 1'b1;
    data_operandA = 32'd2;
    data_operandB = 32'd3;
    for (int c = 1; c <= 68; c++) begin
      @(negedge clock);
      if (c == 40) start = 1'b0;
      exp_busy = (c <= 33) || (c >= 35 && c <= 67);
      exp_rdy  = (c == 33) || (c == 67);
      if (data_resultRDY === 1'b1) rdy_count++;
      n_checks++;
      if (busy !== exp_busy || data_resultRDY !== exp_rdy) begin
        n_fail++;
        $display("FAIL held cycle %0d: got busy=%b rdy=%b expected busy=%b rdy=%b",
                 c, busy, data_resultRDY, exp_busy, exp_rdy);
      end
      if (exp_rdy) begin
        n_checks++;
        if (data_result !== 32'd6 || data_exception !== 1'b0) begin
          n_fail++;
          $display("FAIL held result cycle %0d: got %h exc=%b expected 00000006 exc=0",
                   c, data_result, data_exception);
        end
      end
    end
    n_checks++;
    if (rdy_count != 2) begin
      n_fail++;
      $display("FAIL held rdy_count: got %0d expected 2", rdy_count);
    end
    $display("held start: M=2 Q=3 -> %0d RDY pulses in 68 cycles, result=%h", rdy_count, data_result);
  endtask

  task automatic test_abort;
    start         = 1'b1;
    data_operandA = 32'd4;
    data_operandB = 32'd4;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (c == 1) start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check_all_zero("abort_immediate");
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check_all_zero("abort_held");
    end
    reset_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      n_checks++;
      if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_rdy: got rdy=%b busy=%b expected 0 0", data_resultRDY, busy);
      end
    end
    $display("abort: reset in cycle 10, no RDY observed check done");
    run_op(32'd4, 32'd4, "after_abort");
  endtask

  task automatic test_back_to_back_random;
    logic [31:0] corners [6];
    logic [31:0] m, q;
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0001_0000};
    for (int i = 0; i < 16; i++) begin
      m = $urandom;
      q = $urandom;
      if (i % 3 == 0) m = corners[$urandom_range(0, 5)];
      if (i % 4 == 1) q = corners[$urandom_range(0, 5)];
      if (i % 5 == 2) m = $urandom_range(0, 65535);
      run_op(m, q, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_held();
    test_abort();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
